// File: rtl/iter_shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and defaults for the iterative shift sequencer.
//               Holds the shift-mode and FSM-state enums, the default
//               operand/shift-amount widths and the request mode decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // The unused encoding 2'b11 is folded onto SLL at capture time, so the
    // registered mode only ever holds a legal enum value.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'b01:   m = SRL;
            2'b10:   m = SRA;
            default: m = SLL;
        endcase
        return m;
    endfunction

endpackage : shift_pkg
`default_nettype wire

// File: rtl/iter_shift_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : iter_shift_ctrl_if
// Description : Request/response bundle between the control FSM (master)
//               and the iterative shift sequencer (slave).
//   in_valid_i/in_ready_o   : request handshake
//   data_i/shamt_i/mode_i   : operand, shift amount, shift mode
//   flush_i                 : synchronous abort
//   out_valid_o/out_ready_i : result handshake
//   result_o                : shifted result
//   busy_o                  : sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface iter_shift_ctrl_if
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] data_i;
    logic [SHW-1:0]   shamt_i;
    logic [1:0]       mode_i;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             busy_o;

    // Requester / result consumer side.
    modport master (
        output in_valid_i, data_i, shamt_i, mode_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, busy_o
    );

    // Sequencer side.
    modport slave (
        input  in_valid_i, data_i, shamt_i, mode_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, busy_o
    );
endinterface : iter_shift_ctrl_if
`default_nettype wire

// File: rtl/iter_shift_ctrl_shift1.sv
`default_nettype none
// ============================================================================
// Module      : shift1_unit
// Description : Combinational single-position shifter.
//   data_i : operand
//   mode_i : SLL / SRL / SRA
//   data_o : operand shifted by exactly one position
// Revision    : 1.0 - initial release
// ============================================================================
module shift1_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic [WIDTH-1:0] data_i,
    input  mode_e                 mode_i,
    output logic      [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = {data_i[WIDTH-2:0], 1'b0};
        case (mode_i)
            SRL:     data_o = {1'b0, data_i[WIDTH-1:1]};
            SRA:     data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            default: data_o = {data_i[WIDTH-2:0], 1'b0};
        endcase
    end

endmodule : shift1_unit
`default_nettype wire

// File: rtl/iter_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : iter_shift_ctrl
// Description : Multi-cycle shift sequencer. Captures an operand, then runs
//               it through a 1-bit shift stage once per cycle for shamt
//               cycles, then presents the result until it is consumed.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : request/result bundle (slave side), see iter_shift_ctrl_if
// Revision    : 1.0 - initial release
// ============================================================================
module iter_shift_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW      // must equal clog2(WIDTH)
) (
    input  wire logic          clk_i,
    input  wire logic          rst_n_i,
    iter_shift_ctrl_if.slave   bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SHW-1:0]   cnt_q,   cnt_d;
    mode_e            mode_q,  mode_d;
    logic [WIDTH-1:0] shift_w;

    shift1_unit #(
        .WIDTH (WIDTH)
    ) u_shift1 (
        .data_i (data_q),
        .mode_i (mode_q),
        .data_o (shift_w)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= SLL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        if (bus.flush_i) begin
            // Abort wins over everything, including an accept in IDLE and a
            // transfer in DONE. The operand register is deliberately kept.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        data_d  = bus.data_i;
                        cnt_d   = bus.shamt_i;
                        mode_d  = decode_mode(bus.mode_i);
                        state_d = (bus.shamt_i == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data_d = shift_w;
                    cnt_d  = cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // Returning through IDLE means a new request is never
                    // taken in the same cycle as the result transfer.
                    if (bus.out_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.result_o    = data_q;

endmodule : iter_shift_ctrl
`default_nettype wire

// File: tb/tb_iter_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_shift_ctrl
// Description : Self-checking bench for iter_shift_ctrl. Directed scenarios
//               plus randomized requests compared against an arithmetic
//               reference model (<<, >>, >>>) and the shamt+1 latency rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_shift_ctrl;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    iter_shift_ctrl_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    iter_shift_ctrl #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference result straight from the shift definitions.
    function automatic logic [31:0] model(input logic [31:0] d, input int s, input logic [1:0] m);
        logic [31:0] r;
        case (m)
            2'b01:   r = d >> s;
            2'b10:   r = $unsigned($signed(d) >>> s);
            default: r = d << s;
        endcase
        return r;
    endfunction

    // Full transaction: accept, measure latency, stall the consumer, transfer.
    task automatic send(input logic [31:0] d, input int s, input logic [1:0] m, input int stall);
        logic [31:0] exp;
        int          cyc;
        exp = model(d, s, m);
        @(negedge clk);
        chk_eq("accept_ready", 32'(bus.in_ready_o), 32'd1);
        bus.in_valid_i  = 1'b1;
        bus.data_i      = d;
        bus.shamt_i     = SHW'(s);
        bus.mode_i      = m;
        bus.out_ready_i = 1'b0;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        cyc = 1;
        while (bus.out_valid_o !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk_eq("latency", 32'(cyc), 32'(s + 1));
        chk_eq("result", bus.result_o, exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk_eq("hold_valid", 32'(bus.out_valid_o), 32'd1);
            chk_eq("hold_result", bus.result_o, exp);
        end
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
        chk_eq("back_to_idle", {30'd0, bus.out_valid_o, bus.in_ready_o}, 32'd1);
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid_o !== 1'b0) seen = 1'b1;
        end
        chk_eq(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int cyc;
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.data_i      = '0;
        bus.shamt_i     = '0;
        bus.mode_i      = 2'b00;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_eq("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk_eq("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk_eq("rst_result", bus.result_o, 32'h0);
        chk_eq("rst_busy", 32'(bus.busy_o), 32'd0);

        // Directed shifts.
        send(32'h0000_0003, 4, 2'b00, 3);
        chk_eq("sll_const", model(32'h3, 4, 2'b00), 32'h0000_0030);
        send(32'h8000_0000, 31, 2'b10, 0);
        send(32'h8000_0000, 31, 2'b01, 0);
        send(32'h1234_5678, 3, 2'b11, 1);

        // shamt 0; a request presented while DONE must wait for IDLE.
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.data_i     = 32'hDEAD_BEEF;
        bus.shamt_i    = '0;
        bus.mode_i     = 2'b10;
        @(posedge clk); #1;
        chk_eq("z_latency1", 32'(bus.out_valid_o), 32'd1);
        chk_eq("z_result", bus.result_o, 32'hDEAD_BEEF);
        bus.data_i  = 32'h1234_5678;
        bus.mode_i  = 2'b00;
        @(posedge clk); #1;
        chk_eq("z_done_ignore", bus.result_o, 32'hDEAD_BEEF);
        chk_eq("z_done_valid", 32'(bus.out_valid_o), 32'd1);
        @(negedge clk) bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
        chk_eq("z_no_same_cycle", {30'd0, bus.out_valid_o, bus.in_ready_o}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        chk_eq("z_next_accept", 32'(bus.out_valid_o), 32'd1);
        chk_eq("z_next_result", bus.result_o, 32'h1234_5678);
        @(negedge clk) bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;

        // Flush in cycle 3 of a shamt-10 SLL: two shifts done, data kept.
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.data_i     = 32'h1;
        bus.shamt_i    = SHW'(10);
        bus.mode_i     = 2'b00;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        chk_eq("fl_idle", 32'(bus.in_ready_o), 32'd1);
        chk_eq("fl_busy", 32'(bus.busy_o), 32'd0);
        chk_eq("fl_data_kept", bus.result_o, 32'h4);
        watch_no_valid("fl_no_valid", 15);
        send(32'h1, 1, 2'b00, 0);

        // Flush in DONE drops the result.
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.data_i     = 32'hF0;
        bus.shamt_i    = SHW'(2);
        bus.mode_i     = 2'b01;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        cyc = 1;
        while (bus.out_valid_o !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk_eq("fd_latency", 32'(cyc), 32'd3);
        @(negedge clk) bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        chk_eq("fd_dropped", {30'd0, bus.out_valid_o, bus.in_ready_o}, 32'd1);
        chk_eq("fd_data_kept", bus.result_o, 32'h3C);

        // Flush together with a request in IDLE blocks the accept.
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.flush_i    = 1'b1;
        bus.data_i     = 32'hAAAA;
        bus.shamt_i    = SHW'(3);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        chk_eq("fi_busy", 32'(bus.busy_o), 32'd0);
        chk_eq("fi_no_load", bus.result_o, 32'h3C);

        // Randomized requests against the reference model.
        for (int n = 0; n < 25; n++) begin
            send($urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.data_i     = 32'h0000_FFFF;
        bus.shamt_i    = SHW'(20);
        bus.mode_i     = 2'b00;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_eq("ar_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk_eq("ar_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk_eq("ar_result", bus.result_o, 32'h0);
        chk_eq("ar_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        watch_no_valid("ar_no_stale", 25);
        send(32'h0000_00FF, 8, 2'b00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_iter_shift_ctrl
`default_nettype wire

// File: doc/iter_shift_ctrl.md
Name: iter_shift_ctrl

Overview:
Multi-cycle shift sequencer for the 32-bit datapath. It drives a single 1-bit shift stage once per cycle, so one request can shift an operand by 0..WIDTH-1 positions. Supported modes are logical left, logical right and arithmetic right. It sits between the ALU/control FSM, which issues requests, and the writeback mux, which consumes results, using valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand/result width in bits
SHW, 5, shift-amount width; must equal clog2(WIDTH)

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
in_valid_i  input  1  request valid
in_ready_o  output  1  block can accept a request
data_i  input  WIDTH  operand
shamt_i  input  SHW  shift amount
mode_i  input  2  shift mode: 00 = SLL, 01 = SRL, 10 = SRA, 11 = treated as SLL
flush_i  input  1  synchronous abort
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts the result
result_o  output  WIDTH  shifted result
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous on rst_n_i low:
  - state = IDLE, data register = 0, counter = 0, mode register = SLL.
  - Outputs: in_ready_o = 1, out_valid_o = 0, result_o = 0, busy_o = 0.
- States: IDLE, SHIFT, DONE.
  - in_ready_o = (state == IDLE).
  - out_valid_o = (state == DONE).
  - result_o always reflects the data register.
- IDLE:
  - Accept occurs when in_valid_i = 1 and in_ready_o = 1.
  - On accept: data register <= data_i, counter <= shamt_i, mode register <= mode_i.
  - Next state is DONE if shamt_i == 0, otherwise SHIFT.
- SHIFT: each cycle the data register takes the shift1 output for the registered mode, and counter decrements.
  - shift1 output per mode:
    - SLL: {reg[WIDTH-2:0], 0}
    - SRL: {0, reg[WIDTH-1:1]}
    - SRA: {reg[WIDTH-1], reg[WIDTH-1:1]}
  - When counter == 1, this is the final shift: next state is DONE.
- DONE:
  - Result is held stable while out_ready_i = 0.
  - When out_ready_i = 1, the result transfers and the next state is IDLE.
  - A new request cannot be accepted in the same cycle as the result transfer; it is accepted at the earliest in the following cycle.
- Latency: out_valid_o rises shamt + 1 cycles after the accept edge. Example: shamt = 0 gives 1 cycle, shamt = 31 gives 32 cycles.
- Throughput: at most one request per shamt + 2 cycles.
- in_valid_i while busy is ignored. The requester must hold it until accepted.
- flush_i:
  - Forces state to IDLE from any state on the next edge and has priority over all other transitions.
  - Data register is retained; the counter is cleared.
  - Asserting flush_i in IDLE together with in_valid_i blocks the accept.
  - flush_i in DONE drops the result with no transfer.
- Asynchronous reset mid-SHIFT aborts the operation immediately and applies all reset values.
- Counter:
  - SHW bits wide; no wrap-around is possible because the maximum load is WIDTH-1.
  - The counter never decrements in IDLE or DONE.
- The mode register and counter are unchanged in DONE.

Decomposition:
- Package shift_pkg holds:
  - the mode typedef (2-bit enum SLL/SRL/SRA);
  - the state typedef (IDLE/SHIFT/DONE);
  - the WIDTH and SHW defaults.
- One combinational sub-module, shift1_unit (inputs: data, mode; output: data shifted by 1). It is instantiated once and contains no state.

Test Plan:
- Reset then idle: after rst_n_i release, in_ready_o = 1, out_valid_o = 0, result_o = 0x00000000.
- SLL: data 0x00000003, shamt 4 -> out_valid_o exactly 5 cycles after accept, result 0x00000030. With out_ready_i held low for 3 cycles, result stays stable, then transfers and returns to IDLE.
- SRA vs SRL: data 0x80000000, shamt 31:
  - SRA -> 0xFFFFFFFF after 32 cycles.
  - SRL -> 0x00000001.
- shamt 0 with mode SRA, data 0xDEADBEEF -> out_valid_o 1 cycle after accept, result 0xDEADBEEF. A request presented while in DONE is not accepted.
- flush_i asserted on cycle 3 of a shamt-10 SLL -> IDLE next cycle, out_valid_o never asserts. A following request (0x1, shamt 1) yields 0x2.
- rst_n_i pulsed low mid-SHIFT, asynchronous relative to the clock -> outputs take reset values immediately, no stale out_valid_o after release.
